// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if
//   Bundles the requester, round-core and result signals of aes_round_sequencer.
//   slave  : the sequencer (takes requests, drives the round core, offers results)
//   master : the environment (requesters A/B, round core, result consumer)
//   Requester A/B : req, mode, ksize, data in; gnt out; err shared
//   Round core    : rnd_state/idx/first/last/dec/ksize out; rnd_result in
//   Result        : done_valid/id/data out; done_ready in; busy out
interface aes_round_sequencer_if #(
  parameter int DATA_W = 128,
  parameter int IDX_W  = 4
);
  logic              req_a;
  logic              mode_a;
  logic [1:0]        ksize_a;
  logic [DATA_W-1:0] data_a;
  logic              gnt_a;
  logic              req_b;
  logic              mode_b;
  logic [1:0]        ksize_b;
  logic [DATA_W-1:0] data_b;
  logic              gnt_b;
  logic              err;
  logic [DATA_W-1:0] rnd_state;
  logic [DATA_W-1:0] rnd_result;
  logic [IDX_W-1:0]  rnd_idx;
  logic              rnd_first;
  logic              rnd_last;
  logic              rnd_dec;
  logic [1:0]        rnd_ksize;
  logic              busy;
  logic              done_valid;
  logic              done_id;
  logic [DATA_W-1:0] done_data;
  logic              done_ready;

  modport slave (
    input  req_a, mode_a, ksize_a, data_a,
    input  req_b, mode_b, ksize_b, data_b,
    input  rnd_result, done_ready,
    output gnt_a, gnt_b, err,
    output rnd_state, rnd_idx, rnd_first, rnd_last, rnd_dec, rnd_ksize,
    output busy, done_valid, done_id, done_data
  );

  modport master (
    output req_a, mode_a, ksize_a, data_a,
    output req_b, mode_b, ksize_b, data_b,
    output rnd_result, done_ready,
    input  gnt_a, gnt_b, err,
    input  rnd_state, rnd_idx, rnd_first, rnd_last, rnd_dec, rnd_ksize,
    input  busy, done_valid, done_id, done_data
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Shares a one-round-per-clock AES datapath between requesters A and B.
//   Arbitrates round-robin, holds the working state register, sequences the
//   round index/first/last flags for Nr+1 cycles and offers the result on a
//   valid/ready port.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : aes_round_sequencer_if.slave (requests, round core, result)
//
//   state | meaning
//   IDLE  | waiting for a request; arbitration happens here only
//   RUN   | one AES round per cycle, cnt = 0 .. Nr
//   DONE  | result held on done_* until done_ready
module aes_round_sequencer #(
  parameter int DATA_W = 128,
  parameter int IDX_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_round_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_t;

  fsm_t              fsm, fsm_nxt;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  nr;
  logic [DATA_W-1:0] work;
  logic              dec_q;
  logic [1:0]        ksize_q;
  logic              id_q;
  logic              last_b;
  logic              gnt_a_q, gnt_b_q, err_q;

  logic              cand_a, cand_b;
  logic              pick_a, pick_b;
  logic              take, illegal, accept;
  logic              sel_mode;
  logic [1:0]        sel_ksize;
  logic [DATA_W-1:0] sel_data;
  logic              run;

  // Nr = 10 / 12 / 14 for ksize 0 / 1 / 2
  assign nr  = IDX_W'(4'd10 + {1'b0, ksize_q, 1'b0});
  assign run = (fsm == RUN);

  // A requester whose grant pulse is still visible has not yet dropped req;
  // masking it keeps an illegal-ksize command from being taken twice.
  always_comb begin
    cand_a    = bus.req_a & ~gnt_a_q;
    cand_b    = bus.req_b & ~gnt_b_q;
    pick_b    = cand_b & (~cand_a | ~last_b);
    pick_a    = cand_a & ~pick_b;
    sel_mode  = pick_b ? bus.mode_b  : bus.mode_a;
    sel_ksize = pick_b ? bus.ksize_b : bus.ksize_a;
    sel_data  = pick_b ? bus.data_b  : bus.data_a;
    take      = (fsm == IDLE) & (pick_a | pick_b);
    illegal   = (sel_ksize == 2'b11);
    accept    = take & ~illegal;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE: if (accept) fsm_nxt = RUN;
      RUN:  if (cnt == nr) fsm_nxt = DONE;
      DONE: if (bus.done_ready) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      work    <= '0;
      dec_q   <= 1'b0;
      ksize_q <= 2'b00;
      id_q    <= 1'b0;
      last_b  <= 1'b1;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      gnt_a_q <= take & pick_a;
      gnt_b_q <= take & pick_b;
      err_q   <= take & illegal;
      // pointer moves even on an illegal command so the other side cannot starve
      if (take) last_b <= pick_b;
      if (accept) begin
        work    <= sel_data;
        dec_q   <= sel_mode;
        ksize_q <= sel_ksize;
        id_q    <= pick_b;
        cnt     <= '0;
      end else if (run) begin
        work <= bus.rnd_result;
        if (cnt != nr) cnt <= cnt + IDX_W'(1);
      end
    end
  end

  assign bus.gnt_a      = gnt_a_q;
  assign bus.gnt_b      = gnt_b_q;
  assign bus.err        = err_q;
  assign bus.rnd_state  = work;
  assign bus.rnd_idx    = run ? (dec_q ? (nr - cnt) : cnt) : '0;
  assign bus.rnd_first  = run & (cnt == '0);
  assign bus.rnd_last   = run & (cnt == nr);
  assign bus.rnd_dec    = dec_q;
  assign bus.rnd_ksize  = ksize_q;
  assign bus.busy       = (fsm != IDLE);
  assign bus.done_valid = (fsm == DONE);
  assign bus.done_id    = id_q;
  assign bus.done_data  = work;

endmodule
